// File: rtl/eb_pkg.sv
// Shared constants and helpers for the eb_rr_arb round-robin arbiter slice.
package eb_pkg;

   localparam int N_DEF     = 4;
   localparam int W_DEF     = 8;
   localparam int NLOG2_DEF = 2;

   // Increment with wrap to 0 at n-1, so non-power-of-2 channel counts never index past n-1.
   function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
      if (v + 1 >= n) return 0;
      return v + 1;
   endfunction

endpackage

// File: rtl/eb_rr_pick.sv
// Combinational wrap-around priority scan: first requester at or after ptr wins.
module eb_rr_pick #(
   parameter int N     = 4,
   parameter int NLOG2 = 2
) (
   input  logic [N-1:0]     req,
   input  logic [NLOG2-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [NLOG2-1:0] idx
);

   int               k;
   logic             found;
   logic [NLOG2-1:0] kk;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      kk    = '0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         kk = NLOG2'(k);
         if (!found && req[kk]) begin
            found     = 1'b1;
            grant[kk] = 1'b1;
            idx       = kk;
         end
      end
   end

endmodule

// File: rtl/eb_rr_arb.sv
// N-to-1 round-robin arbiter with a one-entry registered output slot.
// Define EB_RR_ARB_LOCK_EN to add t_last and hold the grant for a whole packet.
module eb_rr_arb
   import eb_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int NLOG2 = NLOG2_DEF,
   parameter int W     = W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     t_req,
   output logic [N-1:0]     t_ack,
   input  logic [N*W-1:0]   t_data,
`ifdef EB_RR_ARB_LOCK_EN
   input  logic [N-1:0]     t_last,
`endif
   output logic             i_0_req,
   input  logic             i_0_ack,
   output logic [W-1:0]     i_0_data,
   output logic [NLOG2-1:0] i_0_id
);

   // Handshake: a beat moves on a channel in any cycle where req and ack are both 1 at the
   // rising edge; req/data hold until acked, and ack may depend combinationally on req.
   logic             out_ready;
   logic             accept;
   logic             advance;
   logic [N-1:0]     req_elig;
   logic [N-1:0]     grant;
   logic [NLOG2-1:0] win_idx;
   logic [NLOG2-1:0] ptr;
   logic [NLOG2-1:0] ptr_inc;
   logic [W-1:0]     win_data;

`ifdef EB_RR_ARB_LOCK_EN
   logic             lock;
   logic [NLOG2-1:0] lock_id;
   logic [N-1:0]     lock_mask;

   always_comb begin
      lock_mask          = '0;
      lock_mask[lock_id] = 1'b1;
   end

   assign req_elig = lock ? (t_req & lock_mask) : t_req;
   assign advance  = t_last[win_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         lock    <= 1'b0;
         lock_id <= '0;
      end else if (accept) begin
         lock    <= !advance;
         lock_id <= win_idx;
      end
   end
`else
   assign req_elig = t_req;
   assign advance  = 1'b1;
`endif

   eb_rr_pick #(.N(N), .NLOG2(NLOG2)) u_pick (
      .req   (req_elig),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx)
   );

   assign out_ready = !i_0_req || i_0_ack;
   assign accept    = (|req_elig) && out_ready;
   assign t_ack     = grant & {N{out_ready}};
   assign ptr_inc   = NLOG2'(inc_mod(32'(win_idx), N));

   always_comb begin
      win_data = '0;
      for (int k = 0; k < N; k++) begin
         if (grant[k]) win_data = t_data[k*W +: W];
      end
   end

   // A drain and a new accept in the same cycle simply overwrite the slot: no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_0_req  <= 1'b0;
         i_0_data <= '0;
         i_0_id   <= '0;
         ptr      <= '0;
      end else if (accept) begin
         i_0_req  <= 1'b1;
         i_0_data <= win_data;
         i_0_id   <= win_idx;
         if (advance) ptr <= ptr_inc;
      end else if (i_0_ack) begin
         i_0_req  <= 1'b0;
      end
   end

endmodule
